alu_issue: RTL and testbench
============================

# alu_issue

Registered decode/issue stage that sits directly in front of the ALU and produces its operand and control inputs. It accepts one RV32I instruction per cycle with its register-file operands and PC over a valid/ready handshake. It decodes the instruction into ALU operation select, sub/unsigned/arith flags and the two 32-bit operands. A two-entry skid buffer lets it sustain full throughput under downstream backpressure while keeping `o_ready` registered.

## Interface
- No parameters.
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst_n`  in  1  reset; asynchronous, active-low.
- `i_valid`  in  1  upstream instruction valid.
- `o_ready`  out  1  stage can accept; equals "skid entry empty".
- `i_inst`  in  32  RV32I instruction word.
- `i_pc`  in  32  instruction PC.
- `i_rs1_data`  in  32  rs1 register value.
- `i_rs2_data`  in  32  rs2 register value.
- `o_valid`  out  1  issue slot holds a decoded instruction.
- `i_ready`  in  1  downstream (ALU/execute) accepts.
- `o_opsel`  out  3  ALU major operation.
- `o_sub`  out  1  ALU subtract.
- `o_unsigned`  out  1  ALU unsigned compare.
- `o_arith`  out  1  ALU arithmetic right shift.
- `o_op1`  out  32  ALU operand 1.
- `o_op2`  out  32  ALU operand 2.
- `o_branch`  out  1  conditional branch; only the ALU `o_eq`/`o_slt` outputs are consumed.
- `o_br_funct3`  out  3  branch condition (`inst[14:12]`).
- `o_br_offset`  out  32  sign-extended B-immediate.
- `o_illegal`  out  1  unsupported or malformed encoding; all ALU controls are 0.

## Operation
- Decode is performed on input, and the result is registered.
  - Opcode `0110011`, R-type:
    - opsel = funct3, op1 = rs1, op2 = rs2.
    - sub = funct7[5] when funct3 = 000; arith = funct7[5] when funct3 = 101; unsigned = (funct3 = 011).
    - funct7 must be `0000000`, or `0100000` only with funct3 000/101. Anything else is illegal.
  - Opcode `0010011`, I-type ALU:
    - opsel = funct3, op1 = rs1, sub = 0, unsigned = (funct3 = 011).
    - op2 = sign-extended `inst[31:20]`.
    - Shifts (funct3 001/101): op2 = {27'd0, `inst[24:20]`}; arith = `inst[30]` for funct3 101.
    - `inst[31:25]` must be `0000000` for 001, and `0000000`/`0100000` for 101. Anything else is illegal.
  - Opcode `0110111` (LUI): opsel 000, op1 = 0, op2 = {`inst[31:12]`, 12'd0}.
  - Opcode `0010111` (AUIPC): same as LUI except op1 = `i_pc`.
  - Opcode `1100011` (branch): see Configuration.
  - Any other opcode: illegal.
- Non-branch instructions drive `o_branch` = 0, `o_br_funct3` = 0, `o_br_offset` = 0.
- Illegal instructions still issue with `o_valid` = 1, `o_illegal` = 1, and opsel/sub/unsigned/arith/op1/op2 all 0.
- Buffering uses an output register (OUT) and a skid register (SKID). States are EMPTY, ONE (OUT full) and TWO (both full).
  - EMPTY → ONE on accept.
  - ONE stays ONE on accept plus drain; → EMPTY on drain only; → TWO on accept without drain.
  - TWO → ONE on drain: SKID moves to OUT and SKID is cleared.
  - Accept = `i_valid & o_ready`. Drain = `o_valid & i_ready`.
- Instructions issue in acceptance order; none are dropped or duplicated.

## Timing
- Reset (async assert): state EMPTY, `o_valid` = 0, all data/control outputs 0, `o_ready` = 1.
- Latency: an instruction accepted at edge N is presented with `o_valid` = 1 after edge N.
- Throughput is 1 instruction/cycle while `i_ready` = 1.
- Output data is stable while `o_valid & !i_ready`.
- `o_ready` depends only on registered state; there is no combinational path from `i_ready`.
- `o_ready` falls the cycle after entering TWO and rises the cycle after leaving it.
- Accept and drain on the same edge in ONE: OUT is overwritten with the new instruction.
- `i_rst_n` asserted mid-stream: all buffered instructions are discarded immediately and outputs go to reset values. Handshakes during reset are ignored.

## Configuration
- `ALU_ISSUE_BRANCH_EN` defined: opcode `1100011` decodes as a branch.
  - opsel 010, op1 = rs1, op2 = rs2.
  - unsigned = funct3[1]; sub = 0; arith = 0.
  - `o_branch` = 1, `o_br_funct3` = funct3, `o_br_offset` = B-immediate.
  - funct3 010/011 are illegal.
- `ALU_ISSUE_BRANCH_EN` undefined: opcode `1100011` is illegal, and `o_branch`/`o_br_funct3`/`o_br_offset` are tied to 0.

## Test plan
- `sub x3,x1,x2` (`0x402081B3`), rs1 = 5, rs2 = 7, `i_ready` = 1 → next cycle `o_valid` = 1, opsel 000, sub 1, op1 = 5, op2 = 7, illegal 0.
- `srai x5,x6,3` (`0x40335293`), rs1 = `0x80000000` → opsel 101, arith 1, op2 = 3. Same instruction with `inst[31:25]` = `0100001` → `o_illegal` = 1, controls 0.
- `addi x1,x0,-1` (`0xFFF00093`) → opsel 000, sub 0, op2 = `0xFFFFFFFF`. `lui` (`0x123450B7`) → op1 = 0, op2 = `0x12345000`. `auipc` (`0x12345097`) with pc = `0x100` → op1 = `0x100`.
- With `ALU_ISSUE_BRANCH_EN`: `bltu x1,x2,+8` (`0x0020E463`) → o_branch 1, opsel 010, unsigned 1, br_funct3 110, br_offset 8. Without the macro → `o_illegal` = 1.
- Backpressure:
  - Hold `i_ready` = 0 and stream instructions A, B, C back-to-back → A in OUT, B in SKID, `o_ready` = 0 before C is accepted.
  - Release `i_ready` → A, B, C issue in order on consecutive cycles; no loss or duplication.
- Mid-stream reset: assert `i_rst_n` = 0 in state TWO → `o_valid` = 0 and `o_ready` = 1 immediately (asynchronously). After release, the first new instruction issues with 1-cycle latency.

Source files
------------

// File: rtl/alu_issue.sv
// Registered RV32I decode/issue stage feeding ALU operands and controls over valid/ready.
// Latency: 1 cycle from accept to o_valid; sustains 1 instruction/cycle when i_ready=1.
// Backpressure: a two-entry OUT/SKID buffer absorbs a stall; o_ready = SKID empty (registered state only).
//
// Ports: i_clk/i_rst_n (async active-low); upstream i_valid/o_ready with i_inst, i_pc,
// i_rs1_data, i_rs2_data; downstream o_valid/i_ready with o_opsel, o_sub, o_unsigned,
// o_arith, o_op1, o_op2, o_branch, o_br_funct3, o_br_offset, o_illegal.
// Optional feature: define ALU_ISSUE_BRANCH_EN to decode opcode 1100011 as a conditional branch.
module alu_issue (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_inst,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_rs1_data,
    input  logic [31:0] i_rs2_data,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [2:0]  o_opsel,
    output logic        o_sub,
    output logic        o_unsigned,
    output logic        o_arith,
    output logic [31:0] o_op1,
    output logic [31:0] o_op2,
    output logic        o_branch,
    output logic [2:0]  o_br_funct3,
    output logic [31:0] o_br_offset,
    output logic        o_illegal
);

    typedef struct packed {
        logic [2:0]  opsel;
        logic        sub;
        logic        uns;
        logic        arith;
        logic [31:0] op1;
        logic [31:0] op2;
        logic        branch;
        logic [2:0]  br_funct3;
        logic [31:0] br_offset;
        logic        illegal;
    } dec_t;

    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

    state_t state_q, state_d;
    dec_t   out_q, out_d;
    dec_t   skid_q, skid_d;
    dec_t   dec;
    logic   ill;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;

    assign opcode = i_inst[6:0];
    assign funct3 = i_inst[14:12];
    assign funct7 = i_inst[31:25];
    assign imm_i  = {{20{i_inst[31]}}, i_inst[31:20]};

    // Register-index fields are resolved upstream; only their data arrives here.
    logic unused_fields;
    assign unused_fields = ^{i_inst[19:15], i_inst[11:7]};

    always_comb begin
        dec = '0;
        ill = 1'b0;
        case (opcode)
            7'b0110011: begin
                dec.opsel = funct3;
                dec.op1   = i_rs1_data;
                dec.op2   = i_rs2_data;
                dec.sub   = (funct3 == 3'b000) & funct7[5];
                dec.arith = (funct3 == 3'b101) & funct7[5];
                dec.uns   = (funct3 == 3'b011);
                if (!((funct7 == 7'b0000000) ||
                      ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)))))
                    ill = 1'b1;
            end
            7'b0010011: begin
                dec.opsel = funct3;
                dec.op1   = i_rs1_data;
                dec.op2   = imm_i;
                dec.uns   = (funct3 == 3'b011);
                if (funct3 == 3'b001) begin
                    dec.op2 = {27'd0, i_inst[24:20]};
                    if (funct7 != 7'b0000000) ill = 1'b1;
                end else if (funct3 == 3'b101) begin
                    dec.op2   = {27'd0, i_inst[24:20]};
                    dec.arith = i_inst[30];
                    if ((funct7 != 7'b0000000) && (funct7 != 7'b0100000)) ill = 1'b1;
                end
            end
            7'b0110111: begin
                dec.op2 = {i_inst[31:12], 12'd0};
            end
            7'b0010111: begin
                dec.op1 = i_pc;
                dec.op2 = {i_inst[31:12], 12'd0};
            end
`ifdef ALU_ISSUE_BRANCH_EN
            7'b1100011: begin
                // The ALU only produces eq/slt here; the branch unit applies funct3.
                dec.opsel     = 3'b010;
                dec.op1       = i_rs1_data;
                dec.op2       = i_rs2_data;
                dec.uns       = funct3[1];
                dec.branch    = 1'b1;
                dec.br_funct3 = funct3;
                dec.br_offset = {{19{i_inst[31]}}, i_inst[31], i_inst[7],
                                 i_inst[30:25], i_inst[11:8], 1'b0};
                if (funct3[2:1] == 2'b01) ill = 1'b1;
            end
`endif
            default: ill = 1'b1;
        endcase
        // Illegal encodings still issue, but with every ALU control zeroed.
        if (ill) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

    logic accept, drain;
    assign o_ready = (state_q != ST_TWO);
    assign o_valid = (state_q != ST_EMPTY);
    assign accept  = i_valid & o_ready;
    assign drain   = o_valid & i_ready;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    out_d   = dec;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && drain) begin
                    out_d = dec;
                end else if (drain) begin
                    out_d   = '0;
                    state_d = ST_EMPTY;
                end else if (accept) begin
                    skid_d  = dec;
                    state_d = ST_TWO;
                end
            end
            ST_TWO: begin
                // o_ready is low here, so no accept can coincide with the drain.
                if (drain) begin
                    out_d   = skid_q;
                    skid_d  = '0;
                    state_d = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
                out_d   = '0;
                skid_d  = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

    assign o_opsel     = out_q.opsel;
    assign o_sub       = out_q.sub;
    assign o_unsigned  = out_q.uns;
    assign o_arith     = out_q.arith;
    assign o_op1       = out_q.op1;
    assign o_op2       = out_q.op2;
    assign o_branch    = out_q.branch;
    assign o_br_funct3 = out_q.br_funct3;
    assign o_br_offset = out_q.br_offset;
    assign o_illegal   = out_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Testbench for alu_issue: decode vector table checked through an issue-order scoreboard,
// plus backpressure and mid-stream reset sequences.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_alu_issue;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_inst;
    logic [31:0] i_pc;
    logic [31:0] i_rs1_data;
    logic [31:0] i_rs2_data;
    logic        o_valid;
    logic        i_ready;
    logic [2:0]  o_opsel;
    logic        o_sub;
    logic        o_unsigned;
    logic        o_arith;
    logic [31:0] o_op1;
    logic [31:0] o_op2;
    logic        o_branch;
    logic [2:0]  o_br_funct3;
    logic [31:0] o_br_offset;
    logic        o_illegal;

    alu_issue dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_inst      (i_inst),
        .i_pc        (i_pc),
        .i_rs1_data  (i_rs1_data),
        .i_rs2_data  (i_rs2_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_opsel     (o_opsel),
        .o_sub       (o_sub),
        .o_unsigned  (o_unsigned),
        .o_arith     (o_arith),
        .o_op1       (o_op1),
        .o_op2       (o_op2),
        .o_branch    (o_branch),
        .o_br_funct3 (o_br_funct3),
        .o_br_offset (o_br_offset),
        .o_illegal   (o_illegal)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    typedef struct packed {
        logic [2:0]  opsel;
        logic        sub;
        logic        uns;
        logic        arith;
        logic [31:0] op1;
        logic [31:0] op2;
        logic        branch;
        logic [2:0]  bf3;
        logic [31:0] boff;
        logic        ill;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        exp_t        e;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   stalls = 0;
    exp_t exp_q[$];
    int   tag_q[$];

    function automatic exp_t mk(input logic [2:0] opsel, input logic sub, input logic uns,
                                input logic arith, input logic [31:0] op1, input logic [31:0] op2,
                                input logic br, input logic [2:0] bf3, input logic [31:0] boff,
                                input logic ill);
        exp_t r;
        r.opsel = opsel; r.sub = sub; r.uns = uns; r.arith = arith;
        r.op1 = op1; r.op2 = op2; r.branch = br; r.bf3 = bf3; r.boff = boff; r.ill = ill;
        return r;
    endfunction

    function automatic exp_t illegal_exp();
        return mk(3'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 3'd0, 32'd0, 1'b1);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, want);
        end
    endtask

    // Scoreboard: every drained instruction must match the oldest outstanding expectation.
    always @(negedge i_clk) begin
        if (i_rst_n && o_valid && i_ready) begin
            exp_t got;
            exp_t want;
            int   tag;
            got = {o_opsel, o_sub, o_unsigned, o_arith, o_op1, o_op2,
                   o_branch, o_br_funct3, o_br_offset, o_illegal};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_issue: got %h with nothing outstanding", got);
            end else begin
                want = exp_q.pop_front();
                tag  = tag_q.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL issue[%0d]: got opsel=%0d sub=%0b uns=%0b arith=%0b op1=%h op2=%h br=%0b bf3=%0d boff=%h ill=%0b, expected opsel=%0d sub=%0b uns=%0b arith=%0b op1=%h op2=%h br=%0b bf3=%0d boff=%h ill=%0b",
                             tag, got.opsel, got.sub, got.uns, got.arith, got.op1, got.op2,
                             got.branch, got.bf3, got.boff, got.ill,
                             want.opsel, want.sub, want.uns, want.arith, want.op1, want.op2,
                             want.branch, want.bf3, want.boff, want.ill);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the edge that accepted the instruction.
    task automatic send(input int tag, input logic [31:0] inst, input logic [31:0] pc,
                        input logic [31:0] rs1, input logic [31:0] rs2, input exp_t e);
        int n;
        n = 0;
        i_valid    = 1'b1;
        i_inst     = inst;
        i_pc       = pc;
        i_rs1_data = rs1;
        i_rs2_data = rs2;
        while (!o_ready && n < 50) begin
            @(posedge i_clk);
            #1;
            n++;
            stalls++;
        end
        if (!o_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout[%0d]: o_ready=%0b, expected 1 within 50 cycles", tag, o_ready);
        end else begin
            exp_q.push_back(e);
            tag_q.push_back(tag);
        end
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        chk(name, exp_q.size(), 32'd0);
    endtask

    vec_t vecs[15];
    exp_t e_a, e_b, e_c, e_f;

    initial begin
        vecs[0]  = '{"sub",      32'h402081B3, 32'h0, 32'd5,        32'd7,
                     mk(3'd0, 1'b1, 1'b0, 1'b0, 32'd5, 32'd7, 1'b0, 3'd0, 32'd0, 1'b0)};
        vecs[1]  = '{"add",      32'h002081B3, 32'h0, 32'd3,        32'd4,
                     mk(3'd0, 1'b0, 1'b0, 1'b0, 32'd3, 32'd4, 1'b0, 3'd0, 32'd0, 1'b0)};
        vecs[2]  = '{"srai",     32'h40335293, 32'h0, 32'h80000000, 32'h0,
                     mk(3'd5, 1'b0, 1'b0, 1'b1, 32'h80000000, 32'd3, 1'b0, 3'd0, 32'd0, 1'b0)};
        vecs[3]  = '{"srai_bad", 32'h42335293, 32'h0, 32'h80000000, 32'h0, illegal_exp()};
        vecs[4]  = '{"addi_m1",  32'hFFF00093, 32'h0, 32'h11,       32'h22,
                     mk(3'd0, 1'b0, 1'b0, 1'b0, 32'h11, 32'hFFFFFFFF, 1'b0, 3'd0, 32'd0, 1'b0)};
        vecs[5]  = '{"lui",      32'h123450B7, 32'h40, 32'h55,      32'h66,
                     mk(3'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'h12345000, 1'b0, 3'd0, 32'd0, 1'b0)};
        vecs[6]  = '{"auipc",    32'h12345097, 32'h100, 32'h55,     32'h66,
                     mk(3'd0, 1'b0, 1'b0, 1'b0, 32'h100, 32'h12345000, 1'b0, 3'd0, 32'd0, 1'b0)};
`ifdef ALU_ISSUE_BRANCH_EN
        vecs[7]  = '{"bltu",     32'h0020E463, 32'h200, 32'd1,      32'd2,
                     mk(3'd2, 1'b0, 1'b1, 1'b0, 32'd1, 32'd2, 1'b1, 3'd6, 32'd8, 1'b0)};
`else
        vecs[7]  = '{"bltu",     32'h0020E463, 32'h200, 32'd1,      32'd2, illegal_exp()};
`endif
        vecs[8]  = '{"sltu",     32'h0020B1B3, 32'h0, 32'h9,        32'hA,
                     mk(3'd3, 1'b0, 1'b1, 1'b0, 32'h9, 32'hA, 1'b0, 3'd0, 32'd0, 1'b0)};
        vecs[9]  = '{"sll_f7",   32'h402091B3, 32'h0, 32'h9,        32'hA, illegal_exp()};
        vecs[10] = '{"sltiu",    32'h00513093, 32'h0, 32'h77,       32'h0,
                     mk(3'd3, 1'b0, 1'b1, 1'b0, 32'h77, 32'd5, 1'b0, 3'd0, 32'd0, 1'b0)};
        vecs[11] = '{"slli_bad", 32'h40209093, 32'h0, 32'h1,        32'h0, illegal_exp()};
        vecs[12] = '{"sra",      32'h4020D1B3, 32'h0, 32'hF0,       32'h4,
                     mk(3'd5, 1'b0, 1'b0, 1'b1, 32'hF0, 32'h4, 1'b0, 3'd0, 32'd0, 1'b0)};
        vecs[13] = '{"load_op",  32'h00000003, 32'h0, 32'h1,        32'h2, illegal_exp()};
        vecs[14] = '{"andi",     32'hFF00F093, 32'h0, 32'h1234,     32'h0,
                     mk(3'd7, 1'b0, 1'b0, 1'b0, 32'h1234, 32'hFFFFFFF0, 1'b0, 3'd0, 32'd0, 1'b0)};

        e_a = mk(3'd0, 1'b0, 1'b0, 1'b0, 32'hA1, 32'd1, 1'b0, 3'd0, 32'd0, 1'b0);
        e_b = mk(3'd0, 1'b0, 1'b0, 1'b0, 32'hB1, 32'd2, 1'b0, 3'd0, 32'd0, 1'b0);
        e_c = mk(3'd0, 1'b0, 1'b0, 1'b0, 32'hC1, 32'd3, 1'b0, 3'd0, 32'd0, 1'b0);
        e_f = mk(3'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'hABCDE000, 1'b0, 3'd0, 32'd0, 1'b0);

        i_rst_n    = 1'b0;
        i_valid    = 1'b0;
        i_ready    = 1'b0;
        i_inst     = 32'd0;
        i_pc       = 32'd0;
        i_rs1_data = 32'd0;
        i_rs2_data = 32'd0;

        #12;
        chk("reset_o_valid", {31'd0, o_valid}, 32'd0);
        chk("reset_o_ready", {31'd0, o_ready}, 32'd1);
        chk("reset_o_op1", o_op1, 32'd0);
        chk("reset_o_op2", o_op2, 32'd0);
        chk("reset_ctrl", {22'd0, o_opsel, o_sub, o_unsigned, o_arith, o_branch, o_br_funct3},
            32'd0);
        chk("reset_o_illegal", {31'd0, o_illegal}, 32'd0);

        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        i_ready = 1'b1;

        // Decode table streamed back-to-back with the sink always ready.
        stalls = 0;
        for (int i = 0; i < 15; i++) begin
            send(i, vecs[i].inst, vecs[i].pc, vecs[i].rs1, vecs[i].rs2, vecs[i].e);
            if (i == 0) chk("first_latency_o_valid", {31'd0, o_valid}, 32'd1);
        end
        chk("full_throughput_stalls", stalls, 32'd0);
        wait_drain("table_drain");

        // Backpressure: A fills OUT, B fills SKID, C must wait.
        i_ready = 1'b0;
        send(100, 32'h002081B3, 32'h0, 32'hA1, 32'd1, e_a);
        send(101, 32'h002081B3, 32'h0, 32'hB1, 32'd2, e_b);
        chk("bp_o_ready_low", {31'd0, o_ready}, 32'd0);
        chk("bp_o_valid", {31'd0, o_valid}, 32'd1);
        chk("bp_out_holds_a", o_op1, 32'hA1);
        fork
            send(102, 32'h002081B3, 32'h0, 32'hC1, 32'd3, e_c);
            begin
                repeat (3) @(posedge i_clk);
                #1;
                chk("bp_stall_stable_op1", o_op1, 32'hA1);
                chk("bp_stall_stable_op2", o_op2, 32'd1);
                i_ready = 1'b1;
            end
        join
        wait_drain("bp_drain");
        @(negedge i_clk);
        chk("bp_idle_after_drain", {31'd0, o_valid}, 32'd0);
        @(posedge i_clk);
        #1;

        // Mid-stream reset while holding two instructions.
        i_ready = 1'b0;
        send(200, 32'h002081B3, 32'h0, 32'hD1, 32'd4, e_a);
        send(201, 32'h002081B3, 32'h0, 32'hE1, 32'd5, e_b);
        chk("pre_reset_full", {31'd0, o_ready}, 32'd0);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("async_reset_o_valid", {31'd0, o_valid}, 32'd0);
        chk("async_reset_o_ready", {31'd0, o_ready}, 32'd1);
        chk("async_reset_o_op1", o_op1, 32'd0);
        exp_q.delete();
        tag_q.delete();
        i_valid = 1'b1;
        i_inst  = 32'h002081B3;
        i_ready = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        chk("reset_ignores_handshake", {31'd0, o_valid}, 32'd0);
        i_valid = 1'b0;
        i_rst_n = 1'b1;
        send(300, 32'hABCDE0B7, 32'h0, 32'h5, 32'h6, e_f);
        chk("post_reset_latency", {31'd0, o_valid}, 32'd1);
        wait_drain("post_reset_drain");

        repeat (2) @(posedge i_clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: simulation exceeded 50000 time units, expected completion");
        $fatal(1, "timeout");
    end

endmodule
